// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// Shared memory message types and arbiter port identifiers.
package lab2_proc_mem_arbiter_pkg;

    // Same field order and widths as the vc mem-msgs 4-byte request/response.
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam logic [2:0] MEM_MSG_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_MSG_TYPE_WRITE = 3'd1;

    // Port IDs stored in the tracking FIFO.
    typedef enum logic {
        ARB_PORT_IMEM = 1'b0,
        ARB_PORT_DMEM = 1'b1
    } arb_port_e;

    function automatic arb_port_e arb_other(input arb_port_e p);
        return (p == ARB_PORT_IMEM) ? ARB_PORT_DMEM : ARB_PORT_IMEM;
    endfunction

endpackage

// File: rtl/lab2_proc_ArbTagFifo.sv
// In-order tracking FIFO of 1-bit port IDs; depth must be a power of two (2..16).
module lab2_proc_ArbTagFifo #(
    parameter int unsigned p_depth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_push_data,
    input  logic i_pop,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = $clog2(p_depth);

    logic [p_depth-1:0] r_mem;
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [AW:0]        r_count;
    logic               w_push;
    logic               w_pop;

    // Status flags and guarded push/pop strobes.
    always_comb begin
        o_full  = (r_count == (AW+1)'(p_depth));
        o_empty = (r_count == '0);
        o_head  = r_mem[r_head];
        w_push  = i_push & ~o_full;
        w_pop   = i_pop & ~o_empty;
    end

    // Storage and pointers; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Round-robin 2:1 arbiter of imem/dmem onto one memory port; responses
// are steered back in order using a tracking FIFO of issued port IDs.
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int unsigned p_max_out = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  mem_req_4B_t  imem_reqstream_msg,
    input  logic         imem_reqstream_val,
    output logic         imem_reqstream_rdy,
    output mem_resp_4B_t imem_respstream_msg,
    output logic         imem_respstream_val,
    input  logic         imem_respstream_rdy,

    input  mem_req_4B_t  dmem_reqstream_msg,
    input  logic         dmem_reqstream_val,
    output logic         dmem_reqstream_rdy,
    output mem_resp_4B_t dmem_respstream_msg,
    output logic         dmem_respstream_val,
    input  logic         dmem_respstream_rdy,

    output mem_req_4B_t  mem_reqstream_msg,
    output logic         mem_reqstream_val,
    input  logic         mem_reqstream_rdy,
    input  mem_resp_4B_t mem_respstream_msg,
    input  logic         mem_respstream_val,
    output logic         mem_respstream_rdy
);

    arb_port_e r_prio;
    arb_port_e w_grant;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_fifo_head;
    logic      w_req_ok;
    logic      w_resp_ok;
    logic      w_req_fire;
    logic      w_resp_fire;
    logic      w_head_dmem;

    // Request path: grant selection and forwarding. Vals never look at rdys.
    always_comb begin
        w_req_ok           = reset & ~w_fifo_full;
        w_grant            = ARB_PORT_IMEM;
        mem_reqstream_val  = 1'b0;
        mem_reqstream_msg  = imem_reqstream_msg;
        imem_reqstream_rdy = 1'b0;
        dmem_reqstream_rdy = 1'b0;

        if (imem_reqstream_val && dmem_reqstream_val) begin
            w_grant = r_prio;
        end else if (dmem_reqstream_val) begin
            w_grant = ARB_PORT_DMEM;
        end

        if (w_grant == ARB_PORT_DMEM) begin
            mem_reqstream_msg = dmem_reqstream_msg;
        end

        mem_reqstream_val  = w_req_ok & (imem_reqstream_val | dmem_reqstream_val);
        imem_reqstream_rdy = w_req_ok & imem_reqstream_val &
                             (w_grant == ARB_PORT_IMEM) & mem_reqstream_rdy;
        dmem_reqstream_rdy = w_req_ok & dmem_reqstream_val &
                             (w_grant == ARB_PORT_DMEM) & mem_reqstream_rdy;
        w_req_fire         = mem_reqstream_val & mem_reqstream_rdy;
    end

    // Response path: FIFO head picks the destination port.
    always_comb begin
        w_resp_ok           = reset & ~w_fifo_empty;
        w_head_dmem         = (w_fifo_head == ARB_PORT_DMEM);
        imem_respstream_msg = mem_respstream_msg;
        dmem_respstream_msg = mem_respstream_msg;
        imem_respstream_val = w_resp_ok & ~w_head_dmem & mem_respstream_val;
        dmem_respstream_val = w_resp_ok &  w_head_dmem & mem_respstream_val;
        mem_respstream_rdy  = w_resp_ok &
                              (w_head_dmem ? dmem_respstream_rdy : imem_respstream_rdy);
        w_resp_fire         = mem_respstream_val & mem_respstream_rdy;
    end

    // Priority pointer: after each issued request, favour the port that did not win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= ARB_PORT_IMEM;
        end else if (w_req_fire) begin
            r_prio <= arb_other(w_grant);
        end
    end

    lab2_proc_ArbTagFifo #(
        .p_depth (p_max_out)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_req_fire),
        .i_push_data (w_grant),
        .i_pop       (w_resp_fire),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule

// File: tb/tb_lab2_proc_mem_arbiter.sv
// Directed bench for lab2_proc_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for FIFO-full stall, simultaneous fire and reset.
module tb_lab2_proc_mem_arbiter;
    import lab2_proc_mem_arbiter_pkg::*;

    logic         clk;
    logic         reset;
    mem_req_4B_t  imem_req_msg, dmem_req_msg, mem_req_msg;
    logic         imem_req_val, imem_req_rdy, dmem_req_val, dmem_req_rdy;
    logic         mem_req_val, mem_req_rdy;
    mem_resp_4B_t imem_resp_msg, dmem_resp_msg, mem_resp_msg;
    logic         imem_resp_val, imem_resp_rdy, dmem_resp_val, dmem_resp_rdy;
    logic         mem_resp_val, mem_resp_rdy;

    int checks   = 0;
    int failures = 0;

    lab2_proc_mem_arbiter #(.p_max_out(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_reqstream_msg  (imem_req_msg),
        .imem_reqstream_val  (imem_req_val),
        .imem_reqstream_rdy  (imem_req_rdy),
        .imem_respstream_msg (imem_resp_msg),
        .imem_respstream_val (imem_resp_val),
        .imem_respstream_rdy (imem_resp_rdy),
        .dmem_reqstream_msg  (dmem_req_msg),
        .dmem_reqstream_val  (dmem_req_val),
        .dmem_reqstream_rdy  (dmem_req_rdy),
        .dmem_respstream_msg (dmem_resp_msg),
        .dmem_respstream_val (dmem_resp_val),
        .dmem_respstream_rdy (dmem_resp_rdy),
        .mem_reqstream_msg   (mem_req_msg),
        .mem_reqstream_val   (mem_req_val),
        .mem_reqstream_rdy   (mem_req_rdy),
        .mem_respstream_msg  (mem_resp_msg),
        .mem_respstream_val  (mem_resp_val),
        .mem_respstream_rdy  (mem_resp_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv, dv, mrdy, mrsv, irr, drr;
        logic        e_mval, e_gd, e_irdy, e_drdy, e_irv, e_drv, e_mrsrdy;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic iv, dv, mrdy, mrsv, irr, drr,
        input logic e_mval, e_gd, e_irdy, e_drdy, e_irv, e_drv, e_mrsrdy,
        input logic [31:0] data);
        vec_t v;
        v.iv = iv; v.dv = dv; v.mrdy = mrdy; v.mrsv = mrsv; v.irr = irr; v.drr = drr;
        v.e_mval = e_mval; v.e_gd = e_gd; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
        v.e_irv = e_irv; v.e_drv = e_drv; v.e_mrsrdy = e_mrsrdy; v.data = data;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, dv, mrdy, mrsv, irr, drr);
        imem_req_val  = iv;
        dmem_req_val  = dv;
        mem_req_rdy   = mrdy;
        mem_resp_val  = mrsv;
        imem_resp_rdy = irr;
        dmem_resp_rdy = drr;
    endtask

    // Checks all handshake outputs in the current cycle.
    task automatic chk_hs(input string nm, input logic mval, irdy, drdy, irv, drv, mrsrdy);
        chk1({nm, "_mval"},   mem_req_val,   mval);
        chk1({nm, "_irdy"},   imem_req_rdy,  irdy);
        chk1({nm, "_drdy"},   dmem_req_rdy,  drdy);
        chk1({nm, "_irv"},    imem_resp_val, irv);
        chk1({nm, "_drv"},    dmem_resp_val, drv);
        chk1({nm, "_mrsrdy"}, mem_resp_rdy,  mrsrdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        imem_req_msg = '{MEM_MSG_TYPE_READ, 8'h11, 32'h0000_0200, 2'd0, 32'd0};
        dmem_req_msg = '{MEM_MSG_TYPE_READ, 8'h22, 32'h0000_0400, 2'd0, 32'd0};
        mem_resp_msg = '{MEM_MSG_TYPE_READ, 8'h11, 2'd0, 2'd0, 32'd0};

        //                iv dv mr ms ir dr | mv gd ir dr iv dv mrs | data
        vecs[0]  = mk(0,0,1,0,1,1, 0,0,0,0,0,0,0, 32'h1000);
        vecs[1]  = mk(1,0,1,0,1,1, 1,0,1,0,0,0,0, 32'h1001);
        vecs[2]  = mk(0,0,1,1,1,1, 0,0,0,0,1,0,1, 32'hdeadbeef);
        vecs[3]  = mk(1,1,1,0,1,1, 1,1,0,1,0,0,0, 32'h1003);
        vecs[4]  = mk(1,1,1,1,1,1, 1,0,1,0,0,1,1, 32'h1004);
        vecs[5]  = mk(1,1,0,1,0,1, 1,1,0,0,1,0,0, 32'h1005);
        vecs[6]  = mk(1,1,1,0,1,1, 1,1,0,1,0,0,1, 32'h1006);
        vecs[7]  = mk(0,0,1,1,0,1, 0,0,0,0,1,0,0, 32'h1007);
        vecs[8]  = mk(0,0,1,1,1,1, 0,0,0,0,1,0,1, 32'h1008);
        vecs[9]  = mk(0,0,1,1,0,1, 0,0,0,0,0,1,1, 32'h1009);
        vecs[10] = mk(0,0,1,1,1,1, 0,0,0,0,0,0,0, 32'h100a);
        vecs[11] = mk(0,1,1,0,1,1, 1,1,0,1,0,0,0, 32'h100b);
        vecs[12] = mk(0,0,1,1,1,1, 0,0,0,0,0,1,1, 32'h100c);

        // Reset state while reset is held.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk_hs("in_reset", 0, 0, 0, 0, 0, 0);
        do_reset();

        // Per-cycle vector table.
        for (int unsigned i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].dv, vecs[i].mrdy, vecs[i].mrsv, vecs[i].irr, vecs[i].drr);
            mem_resp_msg.data = vecs[i].data;
            #1;
            chk_hs($sformatf("v%0d", i), vecs[i].e_mval, vecs[i].e_irdy, vecs[i].e_drdy,
                   vecs[i].e_irv, vecs[i].e_drv, vecs[i].e_mrsrdy);
            if (vecs[i].e_mval) begin
                chk32($sformatf("v%0d_addr", i), mem_req_msg.addr,
                      vecs[i].e_gd ? 32'h0000_0400 : 32'h0000_0200);
                chk32($sformatf("v%0d_opq", i), 32'(mem_req_msg.opaque),
                      vecs[i].e_gd ? 32'h22 : 32'h11);
            end
            if (vecs[i].e_irv) chk32($sformatf("v%0d_idata", i), imem_resp_msg.data, vecs[i].data);
            if (vecs[i].e_drv) chk32($sformatf("v%0d_ddata", i), dmem_resp_msg.data, vecs[i].data);
        end

        // Contested requests after reset alternate, responses return in order.
        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            #1;
            chk1($sformatf("rr%0d_irdy", k), imem_req_rdy, k[0] == 1'b0);
            chk1($sformatf("rr%0d_drdy", k), dmem_req_rdy, k[0] == 1'b1);
            chk32($sformatf("rr%0d_addr", k), mem_req_msg.addr,
                  k[0] ? 32'h0000_0400 : 32'h0000_0200);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            chk1($sformatf("rrsp%0d_irv", k), imem_resp_val, k[0] == 1'b0);
            chk1($sformatf("rrsp%0d_drv", k), dmem_resp_val, k[0] == 1'b1);
        end

        // Full FIFO stall: 5th dmem request waits for a pop, issues the cycle after.
        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            #1;
            chk1($sformatf("fill%0d_drdy", k), dmem_req_rdy, 1'b1);
        end
        for (int unsigned k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            #1;
            chk1($sformatf("full%0d_drdy", k), dmem_req_rdy, 1'b0);
            chk1($sformatf("full%0d_mval", k), mem_req_val, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk_hs("fullpop", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk_hs("afterpop", 1, 0, 1, 0, 0, 1);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            chk1($sformatf("drain%0d_drv", k), dmem_resp_val, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk1("drained_mrsrdy", mem_resp_rdy, 1'b0);

        // Simultaneous push and pop at count 2 for 8 cycles (pointers wrap twice).
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk1("pre0_irdy", imem_req_rdy, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk1("pre1_drdy", dmem_req_rdy, 1'b1);
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            chk_hs($sformatf("sim%0d", k), 1, k[0] == 1'b0, k[0] == 1'b1,
                   k[0] == 1'b0, k[0] == 1'b1, 1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk_hs("simtail0", 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        #1;
        chk_hs("simtail1", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        chk_hs("simtail2", 0, 0, 0, 0, 0, 0);

        // Half-cycle reset pulse with 3 transactions outstanding.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk1("out3_irdy", imem_req_rdy, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        chk_hs("rstheld", 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk_hs("rstrel", 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_hs("rstnext", 1, 0, 1, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
